// File: rtl/fp_decode_seq.sv
// Serial decoder from the 8-bit float (S, E, F) to a two's-complement value (-1)^S * F * 2^E.
// One word in flight; the significand is shifted left one bit per cycle, E times.
module fp_decode_seq #(
    parameter int EXP_W = 3,
    parameter int SIG_W = 4,
    // OUT_W must be at least SIG_W + 2**EXP_W so the shifted magnitude plus sign always fits
    parameter int OUT_W = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [EXP_W+SIG_W:0]     in_fp,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [OUT_W-1:0]         out_tc,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int MAG_W = OUT_W - 1;

    // Handshake: a word moves on any rising edge where valid && ready are both high.
    // in_ready is high only in IDLE and out_valid only in OUT, so the two never overlap.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CONV  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t             state;
    logic               sign;
    logic [EXP_W-1:0]   cnt;
    logic [MAG_W-1:0]   mag;

    logic [OUT_W-1:0]   mag_ext;
    logic [OUT_W-1:0]   mag_neg;

    // Negative zero wraps to zero here, so no special case is needed.
    assign mag_ext = {1'b0, mag};
    assign mag_neg = ~mag_ext + OUT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_tc    <= '0;
            sign      <= 1'b0;
            cnt       <= '0;
            mag       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sign     <= in_fp[EXP_W+SIG_W];
                        cnt      <= in_fp[SIG_W +: EXP_W];
                        mag      <= {{(MAG_W-SIG_W){1'b0}}, in_fp[SIG_W-1:0]};
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        mag <= mag << 1;
                        cnt <= cnt - EXP_W'(1);
                    end else begin
                        state <= CONV;
                    end
                end
                CONV: begin
                    out_tc    <= sign ? mag_neg : mag_ext;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_decode_seq.sv
// Directed bench for fp_decode_seq: driver pushes expected words and output cycles,
// an independent monitor pops and compares whenever the DUT presents a word.
module tb_fp_decode_seq;

    logic        clk;
    logic        rst;
    logic [7:0]  in_fp;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] out_tc;
    logic        out_valid;
    logic        out_ready;

    int checks;
    int failures;
    int cyc;

    logic [11:0] exp_q[$];
    int          exp_cyc_q[$];

    fp_decode_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_fp     (in_fp),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_tc    (out_tc),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // drive one word; when keep is set the expected result and output cycle are queued
    task automatic send(input logic [7:0] fp, input logic [11:0] exp_val, input bit keep);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!in_ready && n < 60);
        if (!in_ready) begin
            chk("send_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_fp    = fp;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (keep) begin
            exp_q.push_back(exp_val);
            exp_cyc_q.push_back(cyc + int'(fp[6:4]) + 2);
        end
        chk("in_ready_low_after_accept", 32'(in_ready), 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size() == 0 && in_ready), 32'd1);
    endtask

    // monitor / scoreboard
    initial begin
        logic        prev_v;
        logic [11:0] held;
        prev_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (out_valid && !prev_v) begin
                if (exp_cyc_q.size() == 0) begin
                    chk("unexpected_output", 32'(out_tc), 32'hFFFF_FFFF);
                end else begin
                    chk("latency_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
                end
                held = out_tc;
            end else if (out_valid && prev_v) begin
                chk("out_tc_held", 32'(out_tc), 32'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_transfer", 32'(out_tc), 32'hFFFF_FFFF);
                end else begin
                    chk("out_tc", 32'(out_tc), 32'(exp_q.pop_front()));
                end
            end
            prev_v = out_valid;
        end
    end

    // stimulus
    initial begin
        rst       = 1'b1;
        in_fp     = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks    = 0;
        failures  = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_tc", 32'(out_tc), 32'd0);
        rst = 1'b0;

        send(8'h00, 12'h000, 1'b1);
        drain();
        send(8'h7F, 12'h780, 1'b1);
        drain();
        send(8'hFF, 12'h880, 1'b1);
        drain();
        send(8'hD0, 12'h000, 1'b1);
        drain();
        send(8'h0F, 12'h00F, 1'b1);
        drain();
        send(8'h38, 12'h040, 1'b1);
        drain();
        send(8'h9C, 12'hFE8, 1'b1);
        drain();
        send(8'h61, 12'h040, 1'b1);
        drain();

        // backpressure with stray inputs while the word waits
        out_ready = 1'b0;
        send(8'hA5, 12'hFEC, 1'b1);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 30) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        for (int i = 0; i < 3; i++) begin
            in_fp    = 8'h7F - 8'(i);
            in_valid = (i != 1);
            @(posedge clk);
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid_hold", 32'(out_valid), 32'd1);
            chk("bp_out_tc_hold", 32'(out_tc), 32'hFEC);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_xfer_in_ready", 32'(in_ready), 32'd1);
        chk("post_xfer_out_valid", 32'(out_valid), 32'd0);
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // reset during SHIFT drops the in-flight word
        send(8'h7F, 12'h000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_tc", 32'(out_tc), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        send(8'h13, 12'h006, 1'b1);
        drain();

        repeat (3) @(posedge clk);
        chk("final_queue_empty", 32'(exp_q.size() + exp_cyc_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
